// File: rtl/gbe_wb_pkg.sv
// Shared constants, FSM state type and byte-keep helper for the GbE CPU-attach Wishbone masters.
// Purely declarative: no logic, no latency, no flow control.
package gbe_wb_pkg;

  localparam logic [31:0] REG_BUFFER_SIZES_ADDR = 32'h0000_0018;
  localparam logic [31:0] RX_BUFFER_OFFSET      = 32'h0000_2000;
  localparam logic [31:0] TX_BUFFER_OFFSET      = 32'h0000_1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_CHK,
    ST_DATA_RD,
    ST_DATA_OUT,
    ST_RELEASE_WR
  } drain_state_t;

  // Remainder of bytes in the final word; 0 means a full word.
  function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
    logic [3:0] keep;
    case (rem)
      2'd1:    keep = 4'b1000;
      2'd2:    keep = 4'b1100;
      2'd3:    keep = 4'b1110;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/gbe_wb_single_xfer.sv
// Single Wishbone classic access: cyc/stb rise one cycle after req, held with addr/data until ack,
// error or ACK_TIMEOUT stb cycles; done/fail are combinational in the cycle the bus ends.
module gbe_wb_single_xfer #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        done,
  output logic        fail,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat,
  output logic [3:0]  sel,
  input  logic        ack,
  input  logic        err
);

  logic [7:0] tcnt;
  logic       tmo;

  // An error wins over a simultaneous ack; timeout only applies when no ack arrives.
  always_comb begin
    tmo  = (tcnt == ACK_TIMEOUT - 8'd1) && !ack;
    done = cyc && ack && !err;
    fail = cyc && (err || tmo);
  end

  // Ending the access drops cyc/stb for at least one cycle, which gives the slave its gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc  <= 1'b0;
      stb  <= 1'b0;
      we   <= 1'b0;
      adr  <= '0;
      dat  <= '0;
      sel  <= '0;
      tcnt <= '0;
    end else if (cyc) begin
      if (done || fail) begin
        cyc <= 1'b0;
        stb <= 1'b0;
      end else begin
        tcnt <= tcnt + 8'd1;
      end
    end else if (req) begin
      cyc  <= 1'b1;
      stb  <= 1'b1;
      we   <= req_we;
      adr  <= req_adr;
      dat  <= req_dat;
      sel  <= req_sel;
      tcnt <= '0;
    end
  end

endmodule

// File: rtl/gbe_rx_drain_wbm.sv
// Polls the GbE CPU-attach RX size register, streams the pending frame out one word per access
// (>= 3 cycles/word), stalls the bus while m_ready is low, then releases the buffer.
module gbe_rx_drain_wbm
  import gbe_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [15:0] POLL_INTERVAL = 16'd256,
  parameter logic [12:0] MAX_BYTES     = 13'd2048,
  parameter logic [7:0]  ACK_TIMEOUT   = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        enable,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic        err_pulse
);

  drain_state_t state, state_nxt;

  logic [15:0] poll_cnt;
  logic [12:0] size;
  logic [11:0] nwords;
  logic [11:0] idx;
  logic [1:0]  last_bytes;

  logic        req;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        xfer_done;
  logic        xfer_fail;

  logic        poll_hit;
  logic        is_last;
  logic [12:0] size_raw;
  logic [13:0] size_plus3;

  gbe_wb_single_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .req    (req),
    .req_we (req_we),
    .req_adr(req_adr),
    .req_dat(req_dat),
    .req_sel(req_sel),
    .done   (xfer_done),
    .fail   (xfer_fail),
    .cyc    (wb_cyc_o),
    .stb    (wb_stb_o),
    .we     (wb_we_o),
    .adr    (wb_adr_o),
    .dat    (wb_dat_o),
    .sel    (wb_sel_o),
    .ack    (wb_ack_i),
    .err    (wb_err_i)
  );

  always_comb begin
    poll_hit   = enable && (poll_cnt == POLL_INTERVAL - 16'd1);
    is_last    = (idx == nwords - 12'd1);
    size_raw   = wb_dat_i[12:0];
    size_plus3 = {1'b0, size} + 14'd3;
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req_we    = 1'b0;
    req_adr   = BASE_ADDR + REG_BUFFER_SIZES_ADDR;
    req_dat   = '0;
    req_sel   = 4'hF;
    case (state)
      ST_IDLE: begin
        if (poll_hit) state_nxt = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        req = 1'b1;
        if (xfer_fail)      state_nxt = ST_IDLE;
        else if (xfer_done) state_nxt = ST_CHK;
      end
      ST_CHK: begin
        state_nxt = (size == 13'd0) ? ST_IDLE : ST_DATA_RD;
      end
      ST_DATA_RD: begin
        req     = 1'b1;
        req_adr = BASE_ADDR + RX_BUFFER_OFFSET + {18'd0, idx, 2'b00};
        if (xfer_fail)      state_nxt = ST_IDLE;
        else if (xfer_done) state_nxt = ST_DATA_OUT;
      end
      ST_DATA_OUT: begin
        if (m_valid && m_ready) state_nxt = m_last ? ST_RELEASE_WR : ST_DATA_RD;
      end
      ST_RELEASE_WR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_sel = 4'b0001;
        if (xfer_fail || xfer_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      poll_cnt   <= '0;
      size       <= '0;
      nwords     <= '0;
      idx        <= '0;
      last_bytes <= '0;
      m_data     <= '0;
      m_keep     <= 4'hF;
      m_last     <= 1'b0;
      m_valid    <= 1'b0;
      pkt_count  <= '0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= xfer_fail;
      if (state != ST_IDLE || !enable || poll_hit) begin
        poll_cnt <= '0;
      end else begin
        poll_cnt <= poll_cnt + 16'd1;
      end
      case (state)
        ST_POLL_RD: begin
          if (xfer_done) size <= (size_raw > MAX_BYTES) ? MAX_BYTES : size_raw;
        end
        ST_CHK: begin
          nwords     <= 12'(size_plus3 >> 2);
          last_bytes <= size[1:0];
          idx        <= '0;
        end
        ST_DATA_RD: begin
          if (xfer_done) begin
            m_data  <= wb_dat_i;
            m_valid <= 1'b1;
            m_last  <= is_last;
            m_keep  <= is_last ? keep_from_rem(last_bytes) : 4'hF;
          end
        end
        ST_DATA_OUT: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_keep  <= 4'hF;
            idx     <= idx + 12'd1;
          end
        end
        ST_RELEASE_WR: begin
          if (xfer_done) pkt_count <= pkt_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbe_rx_drain_wbm.sv
// Directed bench: Wishbone slave model plus a stream scoreboard popped by an independent monitor.
module tb_gbe_rx_drain_wbm;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] SZ_A  = BASE + 32'h18;
  localparam logic [31:0] RX_A  = BASE + 32'h2000;
  localparam int          PI    = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        enable;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid, busy, err_pulse;
  logic        m_ready = 1'b1;
  logic [15:0] pkt_count;

  gbe_rx_drain_wbm #(
    .BASE_ADDR    (BASE),
    .POLL_INTERVAL(16'(PI)),
    .MAX_BYTES    (13'd2048),
    .ACK_TIMEOUT  (8'd64)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .enable   (enable),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .pkt_count(pkt_count),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          start;
  } acc_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  acc_t  log_q[$];
  beat_t exp_q[$];

  int n_check = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_check++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Slave model state
  logic [31:0] rx_mem [512];
  logic [31:0] size_reg = 32'h0;
  int          ack_delay = 0;
  logic        block_en  = 1'b0;
  logic [31:0] block_adr = 32'h0;
  int          wait_cnt  = 0;
  int          cyc_n     = 0;
  logic        prev_stb  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_adr  = 32'h0;
  int          stb_len   = 0;
  int          start_cyc = 0;
  int          noack_len = 0;

  always @(posedge clk) cyc_n++;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    logic [31:0] off;
    off = a - RX_A;
    if (a == SZ_A) return size_reg;
    if (a >= RX_A && off < 32'h800) return rx_mem[off[10:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin
    if (prev_ack) check("gap_after_ack", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    if (prev_stb && wb_stb_o && !prev_ack) check("adr_hold", wb_adr_o, prev_adr);
    if (wb_stb_o && !prev_stb) begin
      stb_len   = 0;
      start_cyc = cyc_n;
    end
    if (wb_stb_o) stb_len++;
    if (!wb_stb_o && prev_stb && !prev_ack) noack_len = stb_len;
    prev_ack = 1'b0;
    if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
      if (!(block_en && wb_adr_o == block_adr) && wait_cnt >= ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rd_val(wb_adr_o);
        log_q.push_back('{wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, start_cyc});
        if (wb_we_o && wb_adr_o == SZ_A) size_reg = 32'h0;
        prev_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wb_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
    prev_stb = (wb_stb_o === 1'b1);
    prev_adr = wb_adr_o;
  end

  // Stream monitor and error-pulse watcher
  int          beats_done = 0;
  int          stalled    = 0;
  int          err_total  = 0;
  int          err_run    = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] stall_snap = '0;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_hold", {27'd0, m_valid, m_data, m_keep, m_last}, {27'd0, 1'b1, stall_snap});
      check("stall_bus_quiet", {63'd0, wb_cyc_o}, 64'd0);
    end
    if (m_valid === 1'b1 && m_ready) begin
      if (exp_q.size() == 0) begin
        n_check++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %h keep %h last %b with empty queue", m_data, m_keep, m_last);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {27'd0, m_data, m_keep, m_last}, {27'd0, e.d, e.k, e.l});
      end
      beats_done++;
    end
    prev_stall = (m_valid === 1'b1) && !m_ready;
    if (prev_stall) stalled++;
    stall_snap = {m_data, m_keep, m_last};
    if (err_pulse === 1'b1) begin
      err_total++;
      err_run++;
    end else begin
      if (err_run != 0) check("err_width", 64'(err_run), 64'd1);
      err_run = 0;
    end
  end

  // Ready driver: stalls for stall_left valid cycles once beats_done reaches stall_after
  int stall_after = -1;
  int stall_left  = 0;

  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && beats_done == stall_after) begin
      m_ready = 1'b0;
      if (m_valid) stall_left--;
    end else begin
      m_ready = 1'b1;
    end
  end

  task automatic wait_pkts(input logic [15:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pkt_count == target) break;
    end
    check("pkt_count", pkt_count, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus"}, {57'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 64'd0);
    check({tag, "_adr_dat"}, {wb_adr_o, wb_dat_o}, 64'd0);
    check({tag, "_stream"}, {58'd0, m_valid, m_last, m_keep}, {58'd0, 1'b0, 1'b0, 4'hF});
    check({tag, "_mdata"}, m_data, 64'd0);
    check({tag, "_status"}, {46'd0, busy, err_pulse, pkt_count}, 64'd0);
  endtask

  initial begin
    int n;
    wb_rst_i = 1'b1;
    enable   = 1'b0;
    wb_err_i = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    wb_rst_i = 1'b0;
    enable   = 1'b1;

    // Empty buffer: only status polls
    log_q.delete();
    for (int i = 0; i < 300 && log_q.size() < 3; i++) @(negedge clk);
    check("empty_poll_count", 64'(log_q.size() >= 3), 64'd1);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check("poll_acc", {27'd0, log_q[i].we, log_q[i].adr, log_q[i].sel},
            {27'd0, 1'b0, SZ_A, 4'hF});
      if (i > 0) check_range("poll_spacing", log_q[i].start - log_q[i-1].start, PI, PI + 6);
    end
    check("empty_no_beats", 64'(beats_done), 64'd0);
    check("empty_pkt", pkt_count, 64'd0);

    // 10-byte frame
    rx_mem[0] = 32'hA0A1A2A3;
    rx_mem[1] = 32'hB0B1B2B3;
    rx_mem[2] = 32'hC0C15A5A;
    exp_q.push_back('{32'hA0A1A2A3, 4'hF, 1'b0});
    exp_q.push_back('{32'hB0B1B2B3, 4'hF, 1'b0});
    exp_q.push_back('{32'hC0C15A5A, 4'b1100, 1'b1});
    log_q.delete();
    size_reg = 32'd10;
    wait_pkts(16'd1, 600);
    check("f10_drained", 64'(exp_q.size()), 64'd0);
    n = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        check("f10_release", {27'd0, log_q[i].we, log_q[i].adr, log_q[i].sel},
              {27'd0, 1'b1, SZ_A, 4'b0001});
        check("f10_release_dat", log_q[i].dat, 64'd0);
      end else if (log_q[i].adr != SZ_A) begin
        check("f10_rd_adr", log_q[i].adr, RX_A + 32'(4 * n));
        n++;
      end
    end
    check("f10_data_reads", 64'(n), 64'd3);

    // 8-byte frame with beat 2 stalled for 20 cycles
    rx_mem[0] = 32'h11223344;
    rx_mem[1] = 32'h55667788;
    exp_q.push_back('{32'h11223344, 4'hF, 1'b0});
    exp_q.push_back('{32'h55667788, 4'hF, 1'b1});
    stalled     = 0;
    stall_after = beats_done + 1;
    stall_left  = 20;
    size_reg    = 32'd8;
    wait_pkts(16'd2, 800);
    check("stall_cycles", 64'(stalled), 64'd20);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // 12-byte frame, beat-2 read never acked -> abort, then a clean re-read
    rx_mem[0] = 32'hD0D1D2D3;
    rx_mem[1] = 32'hE0E1E2E3;
    rx_mem[2] = 32'hF0F1F2F3;
    check("err_before", 64'(err_total), 64'd0);
    exp_q.push_back('{32'hD0D1D2D3, 4'hF, 1'b0});
    block_adr = RX_A + 32'h4;
    block_en  = 1'b1;
    size_reg  = 32'd12;
    for (int i = 0; i < 600 && err_total == 0; i++) @(negedge clk);
    block_en = 1'b0;
    check("abort_err_count", 64'(err_total), 64'd1);
    check("abort_timeout_len", 64'(noack_len), 64'd64);
    check("abort_no_release", pkt_count, 64'd2);
    check("abort_partial", 64'(exp_q.size()), 64'd0);
    exp_q.push_back('{32'hD0D1D2D3, 4'hF, 1'b0});
    exp_q.push_back('{32'hE0E1E2E3, 4'hF, 1'b0});
    exp_q.push_back('{32'hF0F1F2F3, 4'hF, 1'b1});
    wait_pkts(16'd3, 800);
    check("reread_drained", 64'(exp_q.size()), 64'd0);

    // Oversized report clamps to 2048 bytes = 512 full words
    for (int i = 0; i < 512; i++) begin
      rx_mem[i] = {16'(i) ^ 16'hC3A5, 16'(i)};
      exp_q.push_back('{{16'(i) ^ 16'hC3A5, 16'(i)}, 4'hF, (i == 511)});
    end
    log_q.delete();
    size_reg = 32'h8000_0FFF;
    wait_pkts(16'd4, 4000);
    check("clamp_drained", 64'(exp_q.size()), 64'd0);
    n = 0;
    foreach (log_q[i]) if (!log_q[i].we && log_q[i].adr != SZ_A) n++;
    check("clamp_data_reads", 64'(n), 64'd512);
    check("clamp_release", 64'(log_q.size() > 0 && log_q[log_q.size()-1].we), 64'd1);

    // Reset while a data read is on the bus
    ack_delay = 3;
    size_reg  = 32'd8;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_stb_o && wb_adr_o == RX_A) begin
        n = 1;
        break;
      end
    end
    check("rst_found_data_rd", 64'(n), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    size_reg  = 32'h0;
    ack_delay = 0;
    wb_rst_i  = 1'b0;
    repeat (40) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_err_total", 64'(err_total), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
